// File: rtl/sm_prog_loader_if.sv
// Stream-in / ROM-write-out signal bundle for sm_prog_loader.
// The loader connects to the slave modport. The byte source and ROM side connect to the master modport.
interface sm_prog_loader_if;
  logic        start;
  logic [7:0]  in_data;
  logic        in_valid;
  logic        in_ready;
  logic        rom_wr;
  logic [31:0] rom_a;
  logic [31:0] rom_data;
  logic        cpu_rst;
  logic        busy;
  logic        done;
  logic        err;

  modport master (
    output start, in_data, in_valid,
    input  in_ready, rom_wr, rom_a, rom_data, cpu_rst, busy, done, err
  );

  modport slave (
    input  start, in_data, in_valid,
    output in_ready, rom_wr, rom_a, rom_data, cpu_rst, busy, done, err
  );
endinterface

// File: rtl/sm_prog_loader.sv
// Length-prefixed byte-stream loader that writes little-endian 32-bit words into an instruction ROM.
// Define SM_PROG_LOADER_CSUM_EN to require a trailing XOR checksum byte.
module sm_prog_loader #(
  parameter int SIZE    = 64,
  parameter int TIMEOUT = 0
) (
  input logic             clk,
  input logic             rst,
  sm_prog_loader_if.slave bus
);

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CNT_LO = 3'd1,
    ST_CNT_HI = 3'd2,
    ST_DATA   = 3'd3,
`ifdef SM_PROG_LOADER_CSUM_EN
    ST_CSUM   = 3'd4,
`endif
    ST_DONE   = 3'd5,
    ST_ERR    = 3'd6
  } state_t;

`ifdef SM_PROG_LOADER_CSUM_EN
  localparam state_t ST_FINISH = ST_CSUM;
`else
  localparam state_t ST_FINISH = ST_DONE;
`endif

  localparam int TMO_W = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  function automatic logic is_loading(input state_t s);
    logic r;
    case (s)
      ST_CNT_LO, ST_CNT_HI, ST_DATA: r = 1'b1;
`ifdef SM_PROG_LOADER_CSUM_EN
      ST_CSUM:                       r = 1'b1;
`endif
      default:                       r = 1'b0;
    endcase
    return r;
  endfunction

  state_t             state_r, state_nx;
  logic [15:0]        count_r, count_nx;
  logic [15:0]        word_idx_r, word_idx_nx;
  logic [1:0]         byte_idx_r, byte_idx_nx;
  logic [23:0]        word_r, word_nx;
  logic [TMO_W-1:0]   tmo_r, tmo_nx;
  logic               in_ready_r, in_ready_nx;
  logic               rom_wr_r, rom_wr_nx;
  logic [31:0]        rom_a_r, rom_a_nx;
  logic [31:0]        rom_data_r, rom_data_nx;
  logic               cpu_rst_r, cpu_rst_nx;
  logic               busy_r, busy_nx;
  logic               done_r, done_nx;
  logic               err_r, err_nx;
  logic               xfer_s;
  logic               tmo_hit_s;
  logic [15:0]        cnt_full_s;
`ifdef SM_PROG_LOADER_CSUM_EN
  logic [7:0]         csum_r, csum_nx;
`endif

  // Next-state, datapath and registered-output values
  always_comb begin
    state_nx    = state_r;
    count_nx    = count_r;
    word_idx_nx = word_idx_r;
    byte_idx_nx = byte_idx_r;
    word_nx     = word_r;
    tmo_nx      = tmo_r;
    rom_wr_nx   = 1'b0;
    rom_data_nx = rom_data_r;
    rom_a_nx    = rom_wr_r ? (rom_a_r + 32'd1) : rom_a_r;
`ifdef SM_PROG_LOADER_CSUM_EN
    csum_nx     = csum_r;
`endif
    xfer_s      = bus.in_valid & in_ready_r;
    tmo_hit_s   = (TIMEOUT > 0) && (32'(tmo_r) == (32'(TIMEOUT) - 32'd1));
    cnt_full_s  = {bus.in_data, count_r[7:0]};

    case (state_r)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (bus.start) begin
          state_nx    = ST_CNT_LO;
          count_nx    = 16'd0;
          word_idx_nx = 16'd0;
          byte_idx_nx = 2'd0;
          word_nx     = 24'd0;
          rom_a_nx    = 32'd0;
`ifdef SM_PROG_LOADER_CSUM_EN
          csum_nx     = 8'd0;
`endif
        end else begin
          state_nx = state_r;
        end
      end
      ST_CNT_LO: begin
        if (xfer_s) begin
          count_nx[7:0] = bus.in_data;
          state_nx      = ST_CNT_HI;
        end else begin
          state_nx = state_r;
        end
      end
      ST_CNT_HI: begin
        if (xfer_s) begin
          count_nx = cnt_full_s;
          if ({16'd0, cnt_full_s} > 32'(SIZE)) begin
            state_nx = ST_ERR;
          end else if (cnt_full_s == 16'd0) begin
            state_nx = ST_FINISH;
          end else begin
            state_nx = ST_DATA;
          end
        end else begin
          state_nx = state_r;
        end
      end
      ST_DATA: begin
        if (xfer_s) begin
          byte_idx_nx = byte_idx_r + 2'd1;
`ifdef SM_PROG_LOADER_CSUM_EN
          csum_nx     = csum_r ^ bus.in_data;
`endif
          if (byte_idx_r == 2'd3) begin
            // Fourth byte completes the word; the strobe and the final state change share an edge
            rom_wr_nx   = 1'b1;
            rom_data_nx = {bus.in_data, word_r};
            word_idx_nx = word_idx_r + 16'd1;
            if ((word_idx_r + 16'd1) == count_r) begin
              state_nx = ST_FINISH;
            end else begin
              state_nx = state_r;
            end
          end else begin
            word_nx[{byte_idx_r, 3'b000} +: 8] = bus.in_data;
          end
        end else begin
          state_nx = state_r;
        end
      end
`ifdef SM_PROG_LOADER_CSUM_EN
      ST_CSUM: begin
        if (xfer_s) begin
          state_nx = (bus.in_data == csum_r) ? ST_DONE : ST_ERR;
        end else begin
          state_nx = state_r;
        end
      end
`endif
      default: begin
        state_nx = ST_IDLE;
      end
    endcase

    if (is_loading(state_r)) begin
      if (xfer_s) begin
        tmo_nx = '0;
      end else if (tmo_hit_s) begin
        tmo_nx   = '0;
        state_nx = ST_ERR;
      end else begin
        tmo_nx = tmo_r + TMO_W'(1);
      end
    end else begin
      tmo_nx = '0;
    end

    in_ready_nx = is_loading(state_nx);
    busy_nx     = is_loading(state_nx);
    done_nx     = (state_nx == ST_DONE);
    err_nx      = (state_nx == ST_ERR);
    cpu_rst_nx  = (state_nx != ST_DONE);
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_nx;
    end
  end

  // Datapath and output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      count_r    <= 16'd0;
      word_idx_r <= 16'd0;
      byte_idx_r <= 2'd0;
      word_r     <= 24'd0;
      tmo_r      <= '0;
      in_ready_r <= 1'b0;
      rom_wr_r   <= 1'b0;
      rom_a_r    <= 32'd0;
      rom_data_r <= 32'd0;
      cpu_rst_r  <= 1'b1;
      busy_r     <= 1'b0;
      done_r     <= 1'b0;
      err_r      <= 1'b0;
`ifdef SM_PROG_LOADER_CSUM_EN
      csum_r     <= 8'd0;
`endif
    end else begin
      count_r    <= count_nx;
      word_idx_r <= word_idx_nx;
      byte_idx_r <= byte_idx_nx;
      word_r     <= word_nx;
      tmo_r      <= tmo_nx;
      in_ready_r <= in_ready_nx;
      rom_wr_r   <= rom_wr_nx;
      rom_a_r    <= rom_a_nx;
      rom_data_r <= rom_data_nx;
      cpu_rst_r  <= cpu_rst_nx;
      busy_r     <= busy_nx;
      done_r     <= done_nx;
      err_r      <= err_nx;
`ifdef SM_PROG_LOADER_CSUM_EN
      csum_r     <= csum_nx;
`endif
    end
  end

  assign bus.in_ready = in_ready_r;
  assign bus.rom_wr   = rom_wr_r;
  assign bus.rom_a    = rom_a_r;
  assign bus.rom_data = rom_data_r;
  assign bus.cpu_rst  = cpu_rst_r;
  assign bus.busy     = busy_r;
  assign bus.done     = done_r;
  assign bus.err      = err_r;

endmodule
